// File: rtl/router_pkg.sv
// Shared router definitions: port indices, crossbar select / destination codes, flit width.
package router_pkg;

  localparam int NPORT  = 3;
  localparam int X      = 0;
  localparam int Y      = 1;
  localparam int LOCAL  = 2;
  localparam int FLIT_W = 40;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_X     = 2'b01;
  localparam logic [1:0] SEL_Y     = 2'b10;
  localparam logic [1:0] SEL_LOCAL = 2'b11;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

  // Port index i is selected/addressed by code i+1; code 00 is reserved for "none".
  function automatic logic [1:0] sel_code(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    case (oh)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/router_switch_allocator_rr_arb3.sv
// Three-request round-robin arbiter: searches from the input after ptr, wrapping x->y->local->x.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    case (ptr)
      2'd0: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd1: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/router_switch_allocator.sv
// Wormhole switch allocator for a 3-port router: per-output round-robin grant with
// packet locking, illegal-destination discard and crossbar select generation.
module router_switch_allocator
  import router_pkg::*;
#(
  parameter logic [1:0] NONE_CODE = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_valid,
  input  logic [2:0] req_tail,
  input  logic [1:0] req_dest_x,
  input  logic [1:0] req_dest_y,
  input  logic [1:0] req_dest_local,
  input  logic [2:0] out_ready,
  output logic [1:0] control_x,
  output logic [1:0] control_y,
  output logic [1:0] control_local,
  output logic [2:0] pop,
  output logic [2:0] err_dest
);

  out_state_e state_q [NPORT];
  out_state_e state_d [NPORT];
  logic [1:0] owner_q [NPORT];
  logic [1:0] owner_d [NPORT];
  logic [1:0] rr_ptr_q [NPORT];
  logic [1:0] rr_ptr_d [NPORT];
  logic [2:0] err_dest_q;

  logic [1:0] dest [NPORT];
  logic [2:0] in_locked;
  logic [2:0] arb_req [NPORT];
  logic [2:0] gnt [NPORT];
  logic [1:0] gnt_idx [NPORT];
  logic [2:0] xfer_locked;
  logic [1:0] control [NPORT];
  logic [2:0] pop_c;
  logic [2:0] err_c;

  assign dest[X]     = req_dest_x;
  assign dest[Y]     = req_dest_y;
  assign dest[LOCAL] = req_dest_local;

  // An input owned by any output must not compete as a head anywhere else.
  always_comb begin
    in_locked = '0;
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (state_q[o] == OUT_LOCKED && owner_q[o] == 2'(i)) in_locked[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      arb_req[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        arb_req[o][i] = req_valid[i] && !in_locked[i] && (dest[i] == sel_code(2'(o)))
                        && (state_q[o] == OUT_IDLE) && out_ready[o];
      end
    end
  end

  for (genvar g = 0; g < NPORT; g++) begin : g_arb
    rr_arb3 u_arb (
      .req (arb_req[g]),
      .ptr (rr_ptr_q[g]),
      .gnt (gnt[g])
    );
  end

  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      gnt_idx[o]     = onehot_to_idx(gnt[o]);
      xfer_locked[o] = (state_q[o] == OUT_LOCKED) && req_valid[owner_q[o]] && out_ready[o];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o]  <= OUT_IDLE;
        owner_q[o]  <= 2'd0;
        rr_ptr_q[o] <= 2'(LOCAL);
      end
      err_dest_q <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
      end
      err_dest_q <= err_c;
    end
  end

  // Next-state: a tail transfer frees the output only from the following cycle on.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
      if (state_q[o] == OUT_IDLE) begin
        if (|gnt[o]) begin
          owner_d[o]  = gnt_idx[o];
          rr_ptr_d[o] = gnt_idx[o];
          state_d[o]  = req_tail[gnt_idx[o]] ? OUT_IDLE : OUT_LOCKED;
        end
      end else if (xfer_locked[o] && req_tail[owner_q[o]]) begin
        state_d[o] = OUT_IDLE;
      end
    end
  end

  // Outputs: crossbar selects, pops and discard of illegal-destination heads.
  always_comb begin
    pop_c = '0;
    err_c = '0;
    for (int o = 0; o < NPORT; o++) begin
      control[o] = NONE_CODE;
      if (|gnt[o]) begin
        control[o] = sel_code(gnt_idx[o]);
        pop_c      = pop_c | gnt[o];
      end else if (xfer_locked[o]) begin
        control[o]          = sel_code(owner_q[o]);
        pop_c[owner_q[o]]   = 1'b1;
      end
    end
    for (int i = 0; i < NPORT; i++) begin
      if (req_valid[i] && !in_locked[i] && dest[i] == SEL_NONE) begin
        pop_c[i] = 1'b1;
        err_c[i] = 1'b1;
      end
    end
  end

  assign control_x     = rst_n ? control[X]     : NONE_CODE;
  assign control_y     = rst_n ? control[Y]     : NONE_CODE;
  assign control_local = rst_n ? control[LOCAL] : NONE_CODE;
  assign pop           = rst_n ? pop_c          : 3'b000;
  assign err_dest      = err_dest_q;

endmodule

// File: tb/tb_router_switch_allocator.sv
// Directed bench for router_switch_allocator: sequential vector table plus a reset-mid-packet sequence.
module tb_router_switch_allocator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_valid = '0;
  logic [2:0] req_tail = '0;
  logic [1:0] req_dest_x = '0;
  logic [1:0] req_dest_y = '0;
  logic [1:0] req_dest_local = '0;
  logic [2:0] out_ready = '0;
  logic [1:0] control_x, control_y, control_local;
  logic [2:0] pop, err_dest;

  int n_cmp  = 0;
  int n_fail = 0;

  router_switch_allocator #(.NONE_CODE(2'b00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_tail       (req_tail),
    .req_dest_x     (req_dest_x),
    .req_dest_y     (req_dest_y),
    .req_dest_local (req_dest_local),
    .out_ready      (out_ready),
    .control_x      (control_x),
    .control_y      (control_y),
    .control_local  (control_local),
    .pop            (pop),
    .err_dest       (err_dest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic [2:0] valid;
    logic [2:0] tail;
    logic [1:0] dx;
    logic [1:0] dy;
    logic [1:0] dl;
    logic [2:0] ready;
    logic [1:0] ecx;
    logic [1:0] ecy;
    logic [1:0] ecl;
    logic [2:0] epop;
    logic [2:0] eerr;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] cx, input logic [1:0] cy,
                         input logic [1:0] cl, input logic [2:0] p, input logic [2:0] e);
    chk({tag, " control_x"},     {1'b0, control_x},     {1'b0, cx});
    chk({tag, " control_y"},     {1'b0, control_y},     {1'b0, cy});
    chk({tag, " control_local"}, {1'b0, control_local}, {1'b0, cl});
    chk({tag, " pop"},           pop,                   p);
    chk({tag, " err_dest"},      err_dest,              e);
  endtask

  initial begin
    //           rst   valid   tail    dx     dy     dl     ready   cx     cy     cl     pop     err
    vecs[0]  = '{1'b0, 3'b111, 3'b111, 2'b01, 2'b01, 2'b01, 3'b111, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    vecs[1]  = '{1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 3'b001, 3'b001, 2'b10, 2'b00, 2'b00, 3'b111, 2'b00, 2'b01, 2'b00, 3'b001, 3'b000};
    vecs[3]  = '{1'b1, 3'b000, 3'b000, 2'b10, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    vecs[4]  = '{1'b1, 3'b010, 3'b010, 2'b00, 2'b10, 2'b00, 3'b111, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000};
    vecs[5]  = '{1'b1, 3'b101, 3'b101, 2'b01, 2'b00, 2'b01, 3'b111, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000};
    vecs[6]  = '{1'b1, 3'b101, 3'b101, 2'b01, 2'b00, 2'b01, 3'b111, 2'b11, 2'b00, 2'b00, 3'b100, 3'b000};
    vecs[7]  = '{1'b1, 3'b101, 3'b101, 2'b01, 2'b00, 2'b01, 3'b111, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000};
    vecs[8]  = '{1'b1, 3'b010, 3'b000, 2'b00, 2'b11, 2'b00, 3'b111, 2'b00, 2'b00, 2'b10, 3'b010, 3'b000};
    vecs[9]  = '{1'b1, 3'b011, 3'b001, 2'b11, 2'b11, 2'b00, 3'b111, 2'b00, 2'b00, 2'b10, 3'b010, 3'b000};
    vecs[10] = '{1'b1, 3'b011, 3'b001, 2'b11, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00, 2'b10, 3'b010, 3'b000};
    vecs[11] = '{1'b1, 3'b011, 3'b011, 2'b11, 2'b11, 2'b00, 3'b111, 2'b00, 2'b00, 2'b10, 3'b010, 3'b000};
    vecs[12] = '{1'b1, 3'b001, 3'b001, 2'b11, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00, 2'b01, 3'b001, 3'b000};
    vecs[13] = '{1'b1, 3'b001, 3'b000, 2'b10, 2'b00, 2'b00, 3'b111, 2'b00, 2'b01, 2'b00, 3'b001, 3'b000};
    vecs[14] = '{1'b1, 3'b011, 3'b010, 2'b10, 2'b10, 2'b00, 3'b101, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    vecs[15] = '{1'b1, 3'b011, 3'b010, 2'b10, 2'b10, 2'b00, 3'b101, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    vecs[16] = '{1'b1, 3'b011, 3'b011, 2'b10, 2'b10, 2'b00, 3'b111, 2'b00, 2'b01, 2'b00, 3'b001, 3'b000};
    vecs[17] = '{1'b1, 3'b010, 3'b010, 2'b00, 2'b10, 2'b00, 3'b111, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000};
    vecs[18] = '{1'b1, 3'b100, 3'b100, 2'b00, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00, 2'b00, 3'b100, 3'b000};
    vecs[19] = '{1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100};
    vecs[20] = '{1'b1, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    vecs[21] = '{1'b1, 3'b001, 3'b001, 2'b01, 2'b00, 2'b00, 3'b110, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    vecs[22] = '{1'b1, 3'b001, 3'b001, 2'b01, 2'b00, 2'b00, 3'b111, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000};
    vecs[23] = '{1'b1, 3'b111, 3'b111, 2'b10, 2'b11, 2'b01, 3'b111, 2'b11, 2'b01, 2'b10, 3'b111, 3'b000};

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst_n;
      req_valid      = vecs[i].valid;
      req_tail       = vecs[i].tail;
      req_dest_x     = vecs[i].dx;
      req_dest_y     = vecs[i].dy;
      req_dest_local = vecs[i].dl;
      out_ready      = vecs[i].ready;
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].ecx, vecs[i].ecy, vecs[i].ecl, vecs[i].epop, vecs[i].eerr);
    end

    // Reset in the middle of a packet from x to out_y, then a fresh head from x.
    @(negedge clk);
    req_valid = 3'b001; req_tail = 3'b000; req_dest_x = 2'b10;
    req_dest_y = 2'b00; req_dest_local = 2'b00; out_ready = 3'b111;
    #1;
    chk_all("rst_head", 2'b00, 2'b01, 2'b00, 3'b001, 3'b000);
    @(negedge clk);
    #1;
    chk_all("rst_body", 2'b00, 2'b01, 2'b00, 3'b001, 3'b000);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("rst_active", 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 3'b001; req_tail = 3'b001; req_dest_x = 2'b11;
    #1;
    chk_all("rst_after", 2'b00, 2'b00, 2'b01, 3'b001, 3'b000);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk_all("rst_idle", 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
